// File: rtl/mesh_done_if.sv
// Signal bundle between the mesh completion monitor and its environment.
// Optional halt-timestamp output is present when MESH_DONE_PERF_EN is defined.
interface mesh_done_if #(
  parameter int NODES   = 16,
  parameter int CYCLE_W = 32
);
  logic [NODES-1:0]   halt_i;
  logic               noc_busy_i;
  logic               clear_i;
  logic [NODES-1:0]   halted_mask_o;
  logic               done_o;
  logic               timeout_o;
  logic [CYCLE_W-1:0] cycle_count_o;
  logic [CYCLE_W-1:0] done_cycle_o;
`ifdef MESH_DONE_PERF_EN
  logic [NODES*CYCLE_W-1:0] halt_stamp_o;
`endif

  modport master (
    output halt_i, noc_busy_i, clear_i,
    input  halted_mask_o, done_o, timeout_o, cycle_count_o, done_cycle_o
`ifdef MESH_DONE_PERF_EN
    , input halt_stamp_o
`endif
  );

  modport slave (
    input  halt_i, noc_busy_i, clear_i,
    output halted_mask_o, done_o, timeout_o, cycle_count_o, done_cycle_o
`ifdef MESH_DONE_PERF_EN
    , output halt_stamp_o
`endif
  );
endinterface

// File: rtl/mesh_done_detector.sv
// Completion monitor for the CPU mesh: sticky done after all halts plus a NoC quiet window,
// with a cycle watchdog. Define MESH_DONE_PERF_EN to add per-node halt timestamps.
module mesh_done_detector #(
  parameter int              NODES        = 16,
  parameter int              QUIET_CYCLES = 64,
  parameter int              CYCLE_W      = 32,
  parameter longint unsigned TIMEOUT      = 1000000
) (
  input logic        clk,
  input logic        rst_n,
  mesh_done_if.slave bus
);

  generate
    if (QUIET_CYCLES < 1) begin : g_bad_quiet
      $error("mesh_done_detector: QUIET_CYCLES must be at least 1");
    end
    if (NODES < 1 || NODES > 64) begin : g_bad_nodes
      $error("mesh_done_detector: NODES must be in 1..64");
    end
  endgenerate

  localparam int                 QW           = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
  localparam logic [QW-1:0]      QUIET_LAST   = QW'(QUIET_CYCLES - 1);
  localparam logic [CYCLE_W-1:0] TIMEOUT_LAST = CYCLE_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_TIMEOUT
  } state_e;

  state_e             r_state,      w_state_nxt;
  logic [NODES-1:0]   r_mask,       w_mask_nxt;
  logic [CYCLE_W-1:0] r_count,      w_count_nxt;
  logic [CYCLE_W-1:0] r_done_cycle, w_done_cycle_nxt;
  logic [QW-1:0]      r_quiet,      w_quiet_nxt;
  logic               r_done,       w_done_nxt;
  logic               r_timeout,    w_timeout_nxt;
  logic [CYCLE_W-1:0] w_count_inc;
  logic               w_active;

  assign w_count_inc = (r_count == {CYCLE_W{1'b1}}) ? r_count : r_count + CYCLE_W'(1);
  assign w_active    = (r_state == S_RUN) || (r_state == S_DRAIN);

  always_comb begin
    // NOTE: every target gets a default before the case so no path leaves one unassigned (no latch).
    w_state_nxt      = r_state;
    w_mask_nxt       = r_mask;
    w_count_nxt      = r_count;
    w_done_cycle_nxt = r_done_cycle;
    w_quiet_nxt      = r_quiet;
    w_done_nxt       = r_done;
    w_timeout_nxt    = r_timeout;

    unique case (r_state)
      S_RUN: begin
        w_mask_nxt  = r_mask | bus.halt_i;
        w_count_nxt = w_count_inc;
        if (r_mask == {NODES{1'b1}}) w_state_nxt = S_DRAIN;
        if (r_count == TIMEOUT_LAST) begin
          w_state_nxt      = S_TIMEOUT;
          w_done_nxt       = 1'b1;
          w_timeout_nxt    = 1'b1;
          w_done_cycle_nxt = w_count_inc;
        end
      end
      S_DRAIN: begin
        w_mask_nxt  = r_mask | bus.halt_i;
        w_count_nxt = w_count_inc;
        // A completing quiet window outranks the watchdog on the same edge.
        if (!bus.noc_busy_i && r_quiet == QUIET_LAST) begin
          w_state_nxt      = S_DONE;
          w_done_nxt       = 1'b1;
          w_done_cycle_nxt = w_count_inc;
        end else begin
          w_quiet_nxt = bus.noc_busy_i ? '0 : r_quiet + QW'(1);
          if (r_count == TIMEOUT_LAST) begin
            w_state_nxt      = S_TIMEOUT;
            w_done_nxt       = 1'b1;
            w_timeout_nxt    = 1'b1;
            w_done_cycle_nxt = w_count_inc;
          end
        end
      end
      S_DONE, S_TIMEOUT: ;
      default: w_state_nxt = S_RUN;
    endcase

    if (bus.clear_i) begin
      w_state_nxt      = S_RUN;
      w_mask_nxt       = '0;
      w_count_nxt      = '0;
      w_done_cycle_nxt = '0;
      w_quiet_nxt      = '0;
      w_done_nxt       = 1'b0;
      w_timeout_nxt    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask       <= '0;
      r_count      <= '0;
      r_done_cycle <= '0;
      r_quiet      <= '0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_mask       <= w_mask_nxt;
      r_count      <= w_count_nxt;
      r_done_cycle <= w_done_cycle_nxt;
      r_quiet      <= w_quiet_nxt;
      r_done       <= w_done_nxt;
      r_timeout    <= w_timeout_nxt;
    end
  end

  assign bus.halted_mask_o = r_mask;
  assign bus.done_o        = r_done;
  assign bus.timeout_o     = r_timeout;
  assign bus.cycle_count_o = r_count;
  assign bus.done_cycle_o  = r_done_cycle;

`ifdef MESH_DONE_PERF_EN
  logic [NODES*CYCLE_W-1:0] r_stamp, w_stamp_nxt;

  // A slice loads only on the first sighting of its halt, i.e. while its mask bit is still clear.
  always_comb begin
    w_stamp_nxt = r_stamp;
    for (int n = 0; n < NODES; n++) begin
      if (w_active && bus.halt_i[n] && !r_mask[n]) w_stamp_nxt[n*CYCLE_W +: CYCLE_W] = r_count;
    end
    if (bus.clear_i) w_stamp_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_stamp <= '0;
    else        r_stamp <= w_stamp_nxt;
  end

  assign bus.halt_stamp_o = r_stamp;
`endif

endmodule

// File: tb/tb_mesh_done_detector.sv
// Directed self-checking bench for mesh_done_detector (16-node instance with a short
// watchdog plus a 1-node instance); slice checks run when MESH_DONE_PERF_EN is defined.
module tb_mesh_done_detector;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  mesh_done_if #(.NODES(16), .CYCLE_W(32)) m  ();
  mesh_done_if #(.NODES(1),  .CYCLE_W(32)) m1 ();

  mesh_done_detector #(.NODES(16), .QUIET_CYCLES(64), .CYCLE_W(32), .TIMEOUT(500)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m)
  );

  mesh_done_detector #(.NODES(1), .QUIET_CYCLES(2), .CYCLE_W(32), .TIMEOUT(100)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    m.halt_i      = '0;
    m.noc_busy_i  = 1'b0;
    m.clear_i     = 1'b0;
    m1.halt_i     = '0;
    m1.noc_busy_i = 1'b0;
    m1.clear_i    = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    m.halt_i      = '0;
    m.noc_busy_i  = 1'b0;
    m.clear_i     = 1'b0;
    m1.halt_i     = '0;
    m1.noc_busy_i = 1'b0;
    m1.clear_i    = 1'b0;
    rst_n = 1'b0;
    #1;
    total++; if (m.done_o !== 1'b0) $display("FAIL reset_done: got %0b want 0", m.done_o); else passed++;
    total++; if (m.cycle_count_o !== 32'd0) $display("FAIL reset_count: got %0d want 0", m.cycle_count_o); else passed++;
    total++; if (m.halted_mask_o !== 16'h0000) $display("FAIL reset_mask: got %h want 0000", m.halted_mask_o); else passed++;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    total++; if (m.cycle_count_o !== 32'd100) $display("FAIL idle_count: got %0d want 100", m.cycle_count_o); else passed++;
    total++; if (m.halted_mask_o !== 16'h0000) $display("FAIL idle_mask: got %h want 0000", m.halted_mask_o); else passed++;
    total++; if (m.done_o !== 1'b0 || m.timeout_o !== 1'b0)
      $display("FAIL idle_flags: got done=%0b timeout=%0b want 0/0", m.done_o, m.timeout_o); else passed++;
  endtask

  task automatic test_halt_sequence();
    int k;
    do_reset();
    for (int n = 0; n < 16; n++) begin
      m.halt_i = 16'(1 << n);
      tick();
    end
    m.halt_i = '0;
    total++; if (m.halted_mask_o !== 16'hFFFF) $display("FAIL seq_mask: got %h want ffff", m.halted_mask_o); else passed++;
    k = 0;
    while (m.done_o !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    total++; if (k !== 65) $display("FAIL seq_done_latency: got %0d cycles want 65", k); else passed++;
    total++; if (m.timeout_o !== 1'b0) $display("FAIL seq_timeout: got %0b want 0", m.timeout_o); else passed++;
    total++; if (m.done_cycle_o !== 32'd81) $display("FAIL seq_done_cycle: got %0d want 81", m.done_cycle_o); else passed++;
    for (int i = 0; i < 5; i++) tick();
    total++; if (m.cycle_count_o !== 32'd81 || m.done_o !== 1'b1)
      $display("FAIL seq_frozen: got count=%0d done=%0b want 81/1", m.cycle_count_o, m.done_o); else passed++;
  endtask

  task automatic test_quiet_restart();
    int k;
    do_reset();
    m.halt_i = 16'hFFFF;
    tick();
    m.halt_i = '0;
    tick();
    for (int i = 0; i < 30; i++) tick();
    m.noc_busy_i = 1'b1;
    tick();
    m.noc_busy_i = 1'b0;
    total++; if (m.done_o !== 1'b0) $display("FAIL quiet_early_done: got %0b want 0", m.done_o); else passed++;
    k = 0;
    while (m.done_o !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    total++; if (k !== 64) $display("FAIL quiet_restart_latency: got %0d cycles want 64", k); else passed++;
    total++; if (m.done_cycle_o !== 32'd97) $display("FAIL quiet_done_cycle: got %0d want 97", m.done_cycle_o); else passed++;
    total++; if (m.timeout_o !== 1'b0) $display("FAIL quiet_timeout: got %0b want 0", m.timeout_o); else passed++;
  endtask

  task automatic test_timeout();
    int k;
    do_reset();
    m.halt_i = 16'hFF7F;
    tick();
    m.halt_i = '0;
    k = 1;
    while (m.done_o !== 1'b1 && k < 600) begin
      tick();
      k++;
    end
    total++; if (k !== 500) $display("FAIL to_cycle: got %0d want 500", k); else passed++;
    total++; if (m.timeout_o !== 1'b1) $display("FAIL to_flag: got %0b want 1", m.timeout_o); else passed++;
    total++; if (m.halted_mask_o !== 16'hFF7F) $display("FAIL to_mask: got %h want ff7f", m.halted_mask_o); else passed++;
    total++; if (m.done_cycle_o !== 32'd500) $display("FAIL to_done_cycle: got %0d want 500", m.done_cycle_o); else passed++;
    m.halt_i = 16'h0080;
    for (int i = 0; i < 3; i++) tick();
    m.halt_i = '0;
    total++; if (m.cycle_count_o !== 32'd500 || m.halted_mask_o !== 16'hFF7F)
      $display("FAIL to_frozen: got count=%0d mask=%h want 500/ff7f", m.cycle_count_o, m.halted_mask_o); else passed++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 434; i++) tick();
    m.halt_i = 16'hFFFF;
    tick();
    m.halt_i = '0;
    for (int i = 0; i < 64; i++) tick();
    total++; if (m.done_o !== 1'b0) $display("FAIL sim_pre_done: got %0b want 0", m.done_o); else passed++;
    tick();
    total++; if (m.done_o !== 1'b1 || m.timeout_o !== 1'b0)
      $display("FAIL sim_priority: got done=%0b timeout=%0b want 1/0", m.done_o, m.timeout_o); else passed++;
    total++; if (m.done_cycle_o !== 32'd500) $display("FAIL sim_done_cycle: got %0d want 500", m.done_cycle_o); else passed++;
  endtask

  task automatic test_clear();
    m.clear_i = 1'b1;
    m.halt_i  = 16'hFFFF;
    tick();
    m.clear_i = 1'b0;
    m.halt_i  = '0;
    total++; if (m.done_o !== 1'b0 || m.timeout_o !== 1'b0 || m.halted_mask_o !== 16'h0000)
      $display("FAIL clr_flags: got done=%0b timeout=%0b mask=%h want 0/0/0000", m.done_o, m.timeout_o, m.halted_mask_o);
    else passed++;
    total++; if (m.cycle_count_o !== 32'd0 || m.done_cycle_o !== 32'd0)
      $display("FAIL clr_counts: got count=%0d done_cycle=%0d want 0/0", m.cycle_count_o, m.done_cycle_o); else passed++;
    tick();
    total++; if (m.cycle_count_o !== 32'd1) $display("FAIL clr_restart: got %0d want 1", m.cycle_count_o); else passed++;
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    m.halt_i = 16'hFFFF;
    tick();
    m.halt_i = '0;
    for (int i = 0; i < 6; i++) tick();
    rst_n = 1'b0;
    #1;
    total++; if (m.halted_mask_o !== 16'h0000 || m.cycle_count_o !== 32'd0 || m.done_o !== 1'b0)
      $display("FAIL rst_async: got mask=%h count=%0d done=%0b want 0000/0/0", m.halted_mask_o, m.cycle_count_o, m.done_o);
    else passed++;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) tick();
    total++; if (m.done_o !== 1'b0 || m.cycle_count_o !== 32'd64)
      $display("FAIL rst_back_to_run: got done=%0b count=%0d want 0/64", m.done_o, m.cycle_count_o); else passed++;
  endtask

  task automatic test_single_node();
    do_reset();
    m1.halt_i = 1'b1;
    tick();
    m1.halt_i = 1'b0;
    total++; if (m1.halted_mask_o !== 1'b1) $display("FAIL one_mask: got %0b want 1", m1.halted_mask_o); else passed++;
    tick();
    tick();
    total++; if (m1.done_o !== 1'b0) $display("FAIL one_early: got %0b want 0", m1.done_o); else passed++;
    tick();
    total++; if (m1.done_o !== 1'b1 || m1.done_cycle_o !== 32'd4)
      $display("FAIL one_done: got done=%0b done_cycle=%0d want 1/4", m1.done_o, m1.done_cycle_o); else passed++;
  endtask

`ifdef MESH_DONE_PERF_EN
  task automatic test_perf();
    logic [31:0] s;
    do_reset();
    for (int i = 0; i < 42; i++) tick();
    m.halt_i = 16'h0008;
    tick();
    for (int i = 0; i < 7; i++) tick();
    m.halt_i = 16'h0020;
    tick();
    m.halt_i = 16'h0028;
    for (int i = 0; i < 3; i++) tick();
    m.halt_i = '0;
    s = m.halt_stamp_o[3*32 +: 32];
    total++; if (s !== 32'd42) $display("FAIL perf_slice3: got %0d want 42", s); else passed++;
    s = m.halt_stamp_o[5*32 +: 32];
    total++; if (s !== 32'd50) $display("FAIL perf_slice5: got %0d want 50", s); else passed++;
    s = m.halt_stamp_o[0 +: 32];
    total++; if (s !== 32'd0) $display("FAIL perf_slice0: got %0d want 0", s); else passed++;
    m.clear_i = 1'b1;
    tick();
    m.clear_i = 1'b0;
    s = m.halt_stamp_o[3*32 +: 32];
    total++; if (s !== 32'd0) $display("FAIL perf_clear: got %0d want 0", s); else passed++;
  endtask
`endif

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    test_reset();
    test_halt_sequence();
    test_quiet_restart();
    test_timeout();
    test_simultaneous();
    test_clear();
    test_reset_mid_drain();
    test_single_node();
`ifdef MESH_DONE_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
